// File: rtl/line_fill_responder.sv
// Cache line-fill responder: takes one fill request, issues a line-aligned bus
// request, gathers BEATS response beats into a line, then pulses mem_data_valid.
module line_fill_responder #(
  parameter int BLOCKSZ = 512,
  parameter int WIDTH   = 64,
  parameter int ADDRW   = 64,
  parameter int BEATS   = BLOCKSZ / WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [ADDRW-1:0]   req_addr,
  output logic               req_ready,
  output logic               bus_req,
  output logic [ADDRW-1:0]   bus_reqaddr,
  input  logic               bus_reqack,
  input  logic [WIDTH-1:0]   bus_resp,
  input  logic               bus_respvalid,
  output logic               bus_respack,
  output logic [BLOCKSZ-1:0] i_block,
  output logic               mem_data_valid
);

  localparam int CNTW = $clog2(BEATS);
  localparam int OFFW = $clog2(BLOCKSZ / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_COLLECT,
    S_DELIVER
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDRW-1:0]   r_addr;
  logic [BLOCKSZ-1:0] r_block;
  logic [CNTW-1:0]    r_cnt;
  logic               w_accept;
  logic               w_beat;
  logic               w_last;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_beat   = (r_state == S_COLLECT) && bus_respvalid;
  assign w_last   = w_beat && (r_cnt == CNTW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_REQ;
      S_REQ:     if (bus_reqack) w_next = S_COLLECT;
      S_COLLECT: if (w_last) w_next = S_DELIVER;
      S_DELIVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // The line is cleared only on accept, so it stays readable after delivery
  // until the next request is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_block <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_addr  <= req_addr;
      r_block <= '0;
      r_cnt   <= '0;
    end else if (w_beat) begin
      r_block[int'(r_cnt) * WIDTH +: WIDTH] <= bus_resp;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign bus_req        = (r_state == S_REQ);
  assign bus_reqaddr    = {r_addr[ADDRW-1:OFFW], {OFFW{1'b0}}};
  assign bus_respack    = w_beat;
  assign i_block        = r_block;
  assign mem_data_valid = (r_state == S_DELIVER);

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: table of whole fills plus hand-written
// reset-mid-fill sequence; expected lines are rebuilt from each vector's base.
module tb_line_fill_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [63:0]  req_addr;
  logic         req_ready;
  logic         bus_req;
  logic [63:0]  bus_reqaddr;
  logic         bus_reqack;
  logic [63:0]  bus_resp;
  logic         bus_respvalid;
  logic         bus_respack;
  logic [511:0] i_block;
  logic         mem_data_valid;

  int n_chk = 0;
  int n_err = 0;

  line_fill_responder dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .bus_req        (bus_req),
    .bus_reqaddr    (bus_reqaddr),
    .bus_reqack     (bus_reqack),
    .bus_resp       (bus_resp),
    .bus_respvalid  (bus_respvalid),
    .bus_respack    (bus_respack),
    .i_block        (i_block),
    .mem_data_valid (mem_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] exp_reqaddr;
    int          ack_dly;
    bit          gaps;
    bit          noisy;
    logic [63:0] base;
    int          exp_lat;
  } fill_t;

  fill_t vec[4];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_excl(input string name);
    check(name, 512'(int'(bus_req) + int'(bus_respack) + int'(mem_data_valid) <= 1), 512'd1);
  endtask

  task automatic run_fill(input fill_t v, input logic [511:0] prev_blk, output logic [511:0] exp_blk);
    int lat;
    int k;
    int cyc;
    bit ph;
    bit valid;
    for (int b = 0; b < 8; b++) exp_blk[b*64 +: 64] = v.base * 64'(b + 1);
    // Spurious bus traffic while idle must be ignored, including at the accept edge.
    bus_respvalid = 1'b1;
    bus_resp      = '1;
    bus_reqack    = 1'b1;
    #1;
    check("idle_ready", req_ready, 1);
    check("idle_respack", bus_respack, 0);
    check("idle_hold_prev", i_block, prev_blk);
    req_valid = 1'b1;
    req_addr  = v.addr;
    tick();
    lat           = 0;
    req_valid     = v.noisy;
    bus_reqack    = 1'b0;
    bus_respvalid = v.noisy;
    #1;
    check("req_bus_req", bus_req, 1);
    check("req_addr_aligned", bus_reqaddr, v.exp_reqaddr);
    check("req_block_cleared", i_block, 0);
    check("req_ready_low", req_ready, 0);
    check("req_respack", bus_respack, 0);
    for (int d = 0; d < v.ack_dly; d++) begin
      tick();
      lat++;
      check("req_held", bus_req, 1);
      check("req_held_respack", bus_respack, 0);
      check_excl("excl_req");
    end
    bus_reqack = 1'b1;
    tick();
    lat++;
    bus_reqack = 1'b0;
    k   = 0;
    ph  = 1'b0;
    cyc = 0;
    while (k < 8 && cyc < 100) begin
      valid         = !(v.gaps && ph);
      bus_respvalid = valid;
      bus_resp      = valid ? v.base * 64'(k + 1) : '1;
      #1;
      check("collect_respack", bus_respack, valid);
      check("collect_no_mdv", mem_data_valid, 0);
      check("collect_ready_low", req_ready, 0);
      check("collect_no_busreq", bus_req, 0);
      tick();
      lat++;
      if (valid) k++;
      ph = ~ph;
      cyc++;
    end
    check("collect_done_in_budget", 512'(cyc < 100), 1);
    bus_respvalid = 1'b1;
    bus_resp      = '1;
    #1;
    check("deliver_mdv", mem_data_valid, 1);
    check("deliver_latency", 512'(lat), 512'(v.exp_lat));
    check("deliver_block", i_block, exp_blk);
    check("deliver_respack", bus_respack, 0);
    check("deliver_ready_low", req_ready, 0);
    check_excl("excl_deliver");
    tick();
    req_valid     = 1'b0;
    bus_respvalid = 1'b0;
    #1;
    check("post_mdv_low", mem_data_valid, 0);
    check("post_ready", req_ready, 1);
    check("post_block_hold", i_block, exp_blk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_bus_req"}, bus_req, 0);
    check({tag, "_reqaddr"}, bus_reqaddr, 0);
    check({tag, "_respack"}, bus_respack, 0);
    check({tag, "_mdv"}, mem_data_valid, 0);
    check({tag, "_block"}, i_block, 0);
  endtask

  initial begin
    logic [511:0] prev;
    logic [511:0] got;
    vec[0] = '{64'h0000_0000_1000_0A7C, 64'h0000_0000_1000_0A40, 0, 1'b0, 1'b0, 64'h11, 9};
    vec[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 5, 1'b1, 1'b1, 64'h0101_0101_0101_0101, 21};
    vec[2] = '{64'h0000_0000_0000_0040, 64'h0000_0000_0000_0040, 2, 1'b0, 1'b1, 64'hA5A5_0000_0000_0001, 11};
    vec[3] = '{64'h0000_0000_0000_003F, 64'h0000_0000_0000_0000, 0, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0000, 9};

    reset         = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    bus_reqack    = 1'b0;
    bus_resp      = '0;
    bus_respvalid = 1'b0;
    tick();
    tick();
    check_reset_vals("rst_init");
    reset = 1'b0;

    prev = '0;
    for (int i = 0; i < 4; i++) begin
      run_fill(vec[i], prev, got);
      prev = got;
    end

    // Abandon a fill after four beats; reset also sees a request and a beat.
    req_valid = 1'b1;
    req_addr  = 64'h2000_0123;
    tick();
    req_valid  = 1'b0;
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus_respvalid = 1'b1;
      bus_resp      = 64'h5500 + 64'(b);
      tick();
    end
    #1;
    check("mid_block_beat3", i_block[255:192], 64'h5503);
    reset         = 1'b1;
    req_valid     = 1'b1;
    bus_respvalid = 1'b1;
    bus_resp      = 64'h5504;
    tick();
    check_reset_vals("rst_mid");
    reset     = 1'b0;
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus_resp = 64'h5505 + 64'(c);
      #1;
      check("rst_drop_mdv", mem_data_valid, 0);
      check("rst_drop_respack", bus_respack, 0);
      check("rst_drop_block", i_block, 0);
      tick();
    end
    bus_respvalid = 1'b0;
    run_fill(vec[0], 512'd0, got);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/line_fill_responder.md
LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

Interface
REQ-001 Parameters SHALL be BLOCKSZ, default 512, fill line width in bits; WIDTH, default 64, bus beat width; ADDRW, default 64, address width; BEATS, fixed at BLOCKSZ/WIDTH = 8.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  cache requests a line fill.
REQ-005 req_addr  input  ADDRW  fetch address; any byte within the line.
REQ-006 req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready at posedge.
REQ-007 bus_req  output  1  memory-bus request, held until accepted.
REQ-008 bus_reqaddr  output  ADDRW  line-aligned address (latched req_addr with bits [5:0] = 0).
REQ-009 bus_reqack  input  1  bus accepted bus_req.
REQ-010 bus_resp  input  WIDTH  response data beat.
REQ-011 bus_respvalid  input  1  bus_resp is valid this cycle.
REQ-012 bus_respack  output  1  beat consumed this cycle.
REQ-013 i_block  output  BLOCKSZ  assembled line presented to the cache.
REQ-014 mem_data_valid  output  1  one-cycle pulse: i_block complete and valid.

Function
REQ-015 FSM states SHALL be IDLE, REQ, COLLECT, DELIVER.
REQ-016 IDLE: req_ready=1; on accept, latch req_addr, clear i_block to 0, clear beat counter, go to REQ.
REQ-017 REQ: bus_req=1, bus_reqaddr stable; on bus_reqack go to COLLECT; otherwise stay (no timeout).
REQ-018 COLLECT: bus_respack SHALL equal bus_respvalid combinationally; each valid beat k (k=0..7) SHALL be written to i_block[64k+63:64k]; counter increments by 1 per beat.
REQ-019 COLLECT: gaps (bus_respvalid=0) SHALL hold counter and i_block unchanged.
REQ-020 Capture of beat 7 SHALL move to DELIVER on the same edge; counter SHALL wrap to 0 and SHALL NOT overrun i_block.
REQ-021 DELIVER: mem_data_valid=1 for exactly one cycle, i_block complete; next state IDLE unconditionally.
REQ-022 i_block SHALL hold its value after DELIVER until the next request is accepted.
REQ-023 bus_respvalid outside COLLECT SHALL be ignored; bus_respack=0 and no state change.
REQ-024 bus_reqack outside REQ SHALL be ignored.
REQ-025 req_valid outside IDLE SHALL be ignored (req_ready=0); the requester holds it.
REQ-026 Minimum latency: accept at edge N, bus_reqack in cycle N+1, 8 consecutive beats in cycles N+2..N+9, mem_data_valid in cycle N+10.
REQ-027 bus_req, bus_respack and mem_data_valid SHALL be mutually exclusive in any cycle.

Reset
REQ-028 Reset SHALL force IDLE, counter=0, latched address=0, i_block=0, bus_req=0, bus_reqaddr=0, bus_respack=0, mem_data_valid=0, req_ready=1 in the cycle after the reset edge.
REQ-029 Reset in any state, including mid-COLLECT, SHALL abandon the fill with no mem_data_valid pulse; beats arriving during or after reset until the next COLLECT SHALL be dropped.
REQ-030 Reset SHALL take priority over every simultaneous event at the same edge.

Verification
REQ-031 Back-to-back fill: req_addr=0x1000_0A7C, bus_reqack next cycle, beats 0x11..0x88 consecutive -> bus_reqaddr=0x1000_0A40, mem_data_valid pulse at accept+10, i_block[63:0]=0x11, i_block[511:448]=0x88.
REQ-032 Stalled bus: bus_reqack delayed 5 cycles, respvalid toggling 1/0 -> bus_req held 5 cycles, bus_respack mirrors respvalid, one mem_data_valid pulse, line correct.
REQ-033 Spurious traffic: bus_respvalid=1 in IDLE and REQ, req_valid=1 during COLLECT -> bus_respack=0, i_block unchanged, second request accepted only after DELIVER.
REQ-034 Reset after beat 3 -> all outputs at reset values, remaining beats ignored, no mem_data_valid; next fill completes correctly.
REQ-035 Two fills back-to-back with distinct data -> i_block holds line 1 until accept of fill 2, then clears to 0; fill 2 data has no residue from fill 1.
